// File: rtl/qspi_arb_pkg.sv
// Shared types and default widths for the QSPI engine arbiter.
package qspi_arb_pkg;

    localparam int unsigned ADDR_W_DEF        = 23;
    localparam int unsigned DATA_W_DEF        = 32;
    localparam int unsigned START_TIMEOUT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_ROM = 1'b0,
        OWN_RAM = 1'b1
    } owner_e;

endpackage

// File: rtl/qspi_arbiter.sv
// Shares one QSPI engine between the fetch path (flash, CS0) and the data path (PSRAM, CS1),
// one transaction at a time, with round-robin on contention and a start timeout.
module qspi_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = ADDR_W_DEF,
    parameter int unsigned DATA_W        = DATA_W_DEF,
    parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              eng_start,
    output logic              eng_write,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [DATA_W-1:0] eng_wdata,
    input  logic [DATA_W-1:0] eng_rdata,
    input  logic              eng_busy,
    input  logic              eng_cs,
    output logic              cs_rom,
    output logic              cs_ram
);

    localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_owner_q, last_owner_d;
    owner_e              pick_c;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                f_ack_q, f_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                eng_start_q, eng_start_d;
    logic                eng_write_q, eng_write_d;
    logic [ADDR_W-1:0]   eng_addr_q, eng_addr_d;
    logic [DATA_W-1:0]   eng_wdata_q, eng_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    // On a tie the requester that did not own the previous grant wins.
    always_comb begin
        if (f_req && d_req) begin
            pick_c = (last_owner_q == OWN_RAM) ? OWN_ROM : OWN_RAM;
        end else if (f_req) begin
            pick_c = OWN_ROM;
        end else begin
            pick_c = OWN_RAM;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        f_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        eng_start_d  = 1'b0;
        eng_write_d  = eng_write_q;
        eng_addr_d   = eng_addr_q;
        eng_wdata_d  = eng_wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (f_req || d_req) begin
                    owner_d     = pick_c;
                    eng_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                    if (pick_c == OWN_ROM) begin
                        eng_write_d = 1'b0;
                        eng_addr_d  = f_addr;
                        eng_wdata_d = '0;
                    end else begin
                        eng_write_d = d_write;
                        eng_addr_d  = d_addr;
                        eng_wdata_d = d_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (eng_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_TIMEOUT)) begin
                    // Engine never acknowledged the start: complete with an error.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    f_ack_d = (owner_q == OWN_ROM);
                    d_ack_d = (owner_q == OWN_RAM);
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!eng_busy) begin
                    rdata_d = eng_write_q ? '0 : eng_rdata;
                    err_d   = 1'b0;
                    f_ack_d = (owner_q == OWN_ROM);
                    d_ack_d = (owner_q == OWN_RAM);
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_ROM;
            last_owner_q <= OWN_RAM;
            cnt_q        <= '0;
            f_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_write_q  <= 1'b0;
            eng_addr_q   <= '0;
            eng_wdata_q  <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            f_ack_q      <= f_ack_d;
            d_ack_q      <= d_ack_d;
            eng_start_q  <= eng_start_d;
            eng_write_q  <= eng_write_d;
            eng_addr_q   <= eng_addr_d;
            eng_wdata_q  <= eng_wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign eng_start = eng_start_q;
    assign eng_write = eng_write_q;
    assign eng_addr  = eng_addr_q;
    assign eng_wdata = eng_wdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

    // Engine CS is routed only to the owning device; idle (or reset) parks both high.
    assign cs_rom = (state_q != ST_IDLE && owner_q == OWN_ROM) ? eng_cs : 1'b1;
    assign cs_ram = (state_q != ST_IDLE && owner_q == OWN_RAM) ? eng_cs : 1'b1;

endmodule

// File: doc/qspi_arbiter.md
# qspi_arbiter

Shares the single QSPI engine and its pins between the instruction-fetch path (flash, CS0) and the data path (PSRAM, CS1). Two requesters (fetch: read-only; data: read/write) issue level-held requests. The arbiter grants one, sequences the engine through one transaction, steers the engine's chip-select to the owning device and returns read data with a one-cycle acknowledge. It sits between `cu`/`registers` and `qspi` in the top level and replaces the hard-wired `start(1)` fetch connection.

## Interface
Parameters:
- `ADDR_W`, 23: byte address width for both requesters and the engine.
- `DATA_W`, 32: read/write data width.
- `START_TIMEOUT`, 8: cycles to wait for `eng_busy` to rise after a start before aborting with error.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `f_req`  in  1  fetch request; held high until `f_ack`.
- `f_addr`  in  ADDR_W  fetch address; sampled at grant.
- `f_ack`  out  1  one-cycle pulse when the fetch completes.
- `d_req`  in  1  data request; held high until `d_ack`.
- `d_write`  in  1  1 = write, 0 = read; sampled at grant.
- `d_addr`  in  ADDR_W  data address; sampled at grant.
- `d_wdata`  in  DATA_W  write data; sampled at grant.
- `d_ack`  out  1  one-cycle pulse when the data access completes.
- `rdata`  out  DATA_W  read data of the last completed transaction; valid with either ack, held until the next ack.
- `err`  out  1  valid with ack; 1 = start timeout.
- `eng_start`  out  1  one-cycle start to the engine.
- `eng_write`, `eng_addr`, `eng_wdata`  out  1/ADDR_W/DATA_W  registered transaction fields to the engine.
- `eng_rdata`  in  DATA_W  engine read data.
- `eng_busy`  in  1  engine busy.
- `eng_cs`  in  1  engine chip-select (active-low).
- `cs_rom`, `cs_ram`  out  1  device chip-selects (active-low).

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: no request -> stay. One request -> grant it. Both -> grant the requester not granted last (round-robin). `last_owner` resets to RAM, so fetch wins the first tie. On grant, latch owner, write (fetch forces 0), address and wdata into `eng_*`, then go to ISSUE.
- ISSUE: `eng_start`=1 for exactly this cycle -> WAIT_BUSY; clear the timeout counter.
- WAIT_BUSY: `eng_busy`=1 -> WAIT_DONE. Otherwise increment the counter. At START_TIMEOUT -> RESP with `err`=1 and `rdata`=0.
- WAIT_DONE: `eng_busy`=0 -> capture `eng_rdata` into `rdata` (writes capture 0), `err`=0 -> RESP.
- RESP: pulse the owner's ack, update `last_owner` -> IDLE.
- CS steering (combinational): owner ROM -> `cs_rom`=`eng_cs`, `cs_ram`=1. Owner RAM -> the mirror. In IDLE both are 1. Both are never low together.
- A requester dropping `req` mid-transaction does not abort it; the ack still pulses.
- Changes to requester address/data after grant are ignored.

## Timing
- Reset values: state IDLE; `f_ack`, `d_ack`, `eng_start`, `eng_write`, `err` = 0; `eng_addr`, `eng_wdata`, `rdata` = 0; `cs_rom`=`cs_ram`=1; `last_owner`=RAM.
- Reset mid-transaction returns to IDLE immediately. No ack is issued. CS lines go high asynchronously.
- Request seen at edge k -> `eng_start` high in cycle k+1.
- Busy-fall sampled at edge n -> ack high in cycle n+1 with `rdata` valid.
- Overhead is 3 cycles plus engine busy time. Back-to-back grants are separated by one IDLE cycle.
- Timeout: `err` ack arrives START_TIMEOUT+2 cycles after `eng_start`.

## Structure
- `qspi_arb_pkg`: state enum, owner enum (`OWN_ROM`, `OWN_RAM`), default widths.
- One module, no sub-modules: the round-robin pick and the timeout counter are small enough to inline.

## Test plan
- Fetch only: `f_req`=1, `f_addr`=0x000100, engine busy 10 cycles returning 0xDEADBEEF -> `eng_start` the cycle after request, `eng_write`=0, `cs_rom` follows `eng_cs`, `f_ack` once with `rdata`=0xDEADBEEF, `err`=0.
- Data write: `d_req`=1, `d_write`=1, `d_addr`=0x0012AB, `d_wdata`=0x00C0FFEE -> engine sees those values, `cs_ram` active, `cs_rom`=1 throughout, `d_ack` once.
- Contention: both requests held high continuously from reset for 4 transactions -> grant order fetch, data, fetch, data; CS lines never both low.
- Timeout: START_TIMEOUT=8, `eng_busy` stuck 0 -> ack 10 cycles after `eng_start` with `err`=1, `rdata`=0.
- Reset in WAIT_DONE: assert `rst` mid-busy -> CS lines go high same cycle, no ack; after release, a fresh fetch completes normally.
- Requester drops `d_req` in WAIT_DONE -> transaction completes and `d_ack` still pulses once.
